// File: rtl/nv_fifo_ctrl_160x65.sv
// ============================================================================
// nv_fifo_ctrl_160x65 : valid/ready controller around a 160x65 two-port RAM
//   with a 4-entry output skid buffer. Optional status: NV_FIFO_CTRL_STATUS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module nv_fifo_ctrl_160x65 #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 65
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic [7:0]       ram_wa,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_di,
    output logic [7:0]       ram_ra,
    output logic             ram_re,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
`ifdef NV_FIFO_CTRL_STATUS_EN
    output logic [7:0]       fifo_count,
    output logic [7:0]       fifo_hwm,
`endif
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam int         C_SKID     = 4;
    localparam logic [7:0] C_DEPTH    = 8'(DEPTH);
    localparam logic [7:0] C_LAST     = 8'(DEPTH - 1);
    localparam logic [2:0] C_CREDITS  = 3'(C_SKID);

    logic [7:0]       r_wr_ptr;
    logic [7:0]       r_rd_ptr;
    logic [7:0]       r_ram_count;
    logic [2:0]       r_credits;
    logic             r_v1;
    logic             r_v2;
    logic [WIDTH-1:0] r_skid [C_SKID];
    logic [1:0]       r_skid_wr;
    logic [1:0]       r_skid_rd;
    logic [2:0]       r_skid_cnt;

    logic             w_accept;
    logic             w_issue;
    logic             w_pop;
    logic [7:0]       w_ram_count_nxt;
    logic [2:0]       w_credits_nxt;

    // Power bus is consumed by the RAM macro itself; no control logic uses it.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign wr_prdy  = nvdla_core_rstn & (r_ram_count < C_DEPTH);
    assign w_accept = wr_pvld & wr_prdy;
    assign w_issue  = nvdla_core_rstn & (r_ram_count != 8'd0) & (r_credits < C_CREDITS);
    assign rd_pvld  = nvdla_core_rstn & (r_skid_cnt != 3'd0);
    assign w_pop    = rd_pvld & rd_prdy;

    assign ram_we  = w_accept;
    assign ram_wa  = nvdla_core_rstn ? r_wr_ptr : 8'd0;
    assign ram_di  = wr_pd;
    assign ram_re  = w_issue;
    assign ram_ra  = nvdla_core_rstn ? r_rd_ptr : 8'd0;
    assign ram_ore = nvdla_core_rstn & r_v1;
    assign rd_pd   = nvdla_core_rstn ? r_skid[r_skid_rd] : '0;

    always_comb begin
        w_ram_count_nxt = r_ram_count;
        w_credits_nxt   = r_credits;
        case ({w_accept, w_issue})
            2'b10:   w_ram_count_nxt = r_ram_count + 8'd1;
            2'b01:   w_ram_count_nxt = r_ram_count - 8'd1;
            default: w_ram_count_nxt = r_ram_count;
        endcase
        // Credits span reads in flight plus skid occupancy, so the skid cannot overflow.
        case ({w_issue, w_pop})
            2'b10:   w_credits_nxt = r_credits + 3'd1;
            2'b01:   w_credits_nxt = r_credits - 3'd1;
            default: w_credits_nxt = r_credits;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr    <= 8'd0;
            r_rd_ptr    <= 8'd0;
            r_ram_count <= 8'd0;
            r_credits   <= 3'd0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_skid_wr   <= 2'd0;
            r_skid_rd   <= 2'd0;
            r_skid_cnt  <= 3'd0;
            for (int i = 0; i < C_SKID; i++) begin
                r_skid[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? 8'd0 : r_wr_ptr + 8'd1;
            end
            if (w_issue) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? 8'd0 : r_rd_ptr + 8'd1;
            end
            r_ram_count <= w_ram_count_nxt;
            r_credits   <= w_credits_nxt;
            r_v1        <= w_issue;
            r_v2        <= r_v1;
            if (r_v2) begin
                r_skid[r_skid_wr] <= ram_dout;
                r_skid_wr         <= r_skid_wr + 2'd1;
            end
            if (w_pop) begin
                r_skid_rd <= r_skid_rd + 2'd1;
            end
            case ({r_v2, w_pop})
                2'b10:   r_skid_cnt <= r_skid_cnt + 3'd1;
                2'b01:   r_skid_cnt <= r_skid_cnt - 3'd1;
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end

`ifdef NV_FIFO_CTRL_STATUS_EN
    localparam logic [8:0] C_MAX_FILL = 9'(DEPTH + C_SKID);

    logic [8:0] w_fill_sum;
    logic [7:0] w_fill;

    // Built from next-state values so fifo_count tracks the current occupancy.
    assign w_fill_sum = {1'b0, w_ram_count_nxt} + {6'd0, w_credits_nxt};
    assign w_fill     = (w_fill_sum > C_MAX_FILL) ? C_MAX_FILL[7:0] : w_fill_sum[7:0];

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            fifo_count <= 8'd0;
            fifo_hwm   <= 8'd0;
        end else begin
            fifo_count <= w_fill;
            if (w_fill > fifo_hwm) begin
                fifo_hwm <= w_fill;
            end
        end
    end
`endif

endmodule

`default_nettype wire
